// File: rtl/dadda_product_accumulator.sv
// Multiply-accumulate back end: sums a burst of unsigned multiplier products
// and presents the total, term count and overflow flag on a registered handshake.
module dadda_product_accumulator #(
    parameter int PROD_W    = 8,
    parameter int ACC_W     = 16,
    parameter int MAX_TERMS = 16,
    parameter bit SATURATE  = 1'b1,
    localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_last,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               ovf;

    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   count_next;
    logic               ovf_next;
    logic               accept;
    logic               done;

    assign in_ready = (state == ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

    // One extra bit of width exposes the carry; a saturated acc stays all-ones
    // because any further nonzero product carries out again.
    always_comb begin
        sum_wide   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_product};
        count_next = count + CNT_W'(1);
        ovf_next   = ovf | sum_wide[ACC_W];
        if (sum_wide[ACC_W] && SATURATE) begin
            acc_next = '1;
        end else begin
            acc_next = sum_wide[ACC_W-1:0];
        end
        done = in_last || (count_next == CNT_W'(MAX_TERMS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ACCUM;
            acc          <= '0;
            count        <= '0;
            ovf          <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else if (state == ACCUM) begin
            if (clear) begin
                acc   <= '0;
                count <= '0;
                ovf   <= 1'b0;
            end else if (accept) begin
                if (done) begin
                    out_sum      <= acc_next;
                    out_count    <= count_next;
                    out_overflow <= ovf_next;
                    out_valid    <= 1'b1;
                    acc          <= '0;
                    count        <= '0;
                    ovf          <= 1'b0;
                    state        <= HOLD;
                end else begin
                    acc   <= acc_next;
                    count <= count_next;
                    ovf   <= ovf_next;
                end
            end
        end else begin
            // Result data is left in place after the handoff.
            if (out_ready) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Scoreboard bench: three accumulator configurations share one stimulus stream
// and are checked against plain-arithmetic burst totals.
module tb_dadda_product_accumulator;

    typedef struct {
        int sum;
        int cnt;
        bit ovf;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_product;
    logic       in_last;
    logic       clear;
    logic       out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [15:0] sum0;
    logic [9:0]  sum1, sum2;
    logic [4:0]  cnt0, cnt1, cnt2;
    logic        of0, of1, of2;

    int   errors;
    int   checks;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t hold_exp[3];

    bit mhold;
    bit last_acc;
    int total;
    int terms;

    dadda_product_accumulator #(.PROD_W(8), .ACC_W(16), .MAX_TERMS(16), .SATURATE(1'b1)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .in_product(in_product), .in_last(in_last), .clear(clear),
        .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
        .out_count(cnt0), .out_overflow(of0));

    dadda_product_accumulator #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16), .SATURATE(1'b1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_product(in_product), .in_last(in_last), .clear(clear),
        .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
        .out_count(cnt1), .out_overflow(of1));

    dadda_product_accumulator #(.PROD_W(8), .ACC_W(10), .MAX_TERMS(16), .SATURATE(1'b0)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .in_product(in_product), .in_last(in_last), .clear(clear),
        .out_valid(ov2), .out_ready(out_ready), .out_sum(sum2),
        .out_count(cnt2), .out_overflow(of2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic exp_t expFor(int tot, int n, int accw, bit sat);
        exp_t e;
        int   lim;
        lim   = 1 << accw;
        e.cnt = n;
        e.ovf = (tot >= lim);
        if (tot >= lim) e.sum = sat ? lim - 1 : tot % lim;
        else            e.sum = tot;
        return e;
    endfunction

    // Consume results only on a real handshake; reset in the same cycle discards them.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_ready) begin
            if (ov0) begin
                if (q0.size() == 0) chk("unexpected_out0", 1, 0);
                else begin
                    e = q0.pop_front();
                    chk("sb0_sum", int'(sum0), e.sum);
                    chk("sb0_count", int'(cnt0), e.cnt);
                    chk("sb0_ovf", int'(of0), int'(e.ovf));
                end
            end
            if (ov1) begin
                if (q1.size() == 0) chk("unexpected_out1", 1, 0);
                else begin
                    e = q1.pop_front();
                    chk("sb1_sum", int'(sum1), e.sum);
                    chk("sb1_count", int'(cnt1), e.cnt);
                    chk("sb1_ovf", int'(of1), int'(e.ovf));
                end
            end
            if (ov2) begin
                if (q2.size() == 0) chk("unexpected_out2", 1, 0);
                else begin
                    e = q2.pop_front();
                    chk("sb2_sum", int'(sum2), e.sum);
                    chk("sb2_count", int'(cnt2), e.cnt);
                    chk("sb2_ovf", int'(of2), int'(e.ovf));
                end
            end
        end
    end

    task automatic checkOutput();
        int want_rdy;
        want_rdy = (!mhold && !clear) ? 1 : 0;
        chk("in_ready0", int'(rdy0), want_rdy);
        chk("in_ready1", int'(rdy1), want_rdy);
        chk("in_ready2", int'(rdy2), want_rdy);
        chk("out_valid0", int'(ov0), int'(mhold));
        chk("out_valid1", int'(ov1), int'(mhold));
        chk("out_valid2", int'(ov2), int'(mhold));
        if (mhold) begin
            chk("hold_sum0", int'(sum0), hold_exp[0].sum);
            chk("hold_sum1", int'(sum1), hold_exp[1].sum);
            chk("hold_sum2", int'(sum2), hold_exp[2].sum);
            chk("hold_count0", int'(cnt0), hold_exp[0].cnt);
            chk("hold_ovf1", int'(of1), int'(hold_exp[1].ovf));
            chk("hold_ovf2", int'(of2), int'(hold_exp[2].ovf));
        end
    endtask

    task automatic modelStep();
        last_acc = 1'b0;
        if (reset) begin
            if (mhold) begin
                void'(q0.pop_back());
                void'(q1.pop_back());
                void'(q2.pop_back());
            end
            mhold = 1'b0;
            total = 0;
            terms = 0;
        end else if (mhold) begin
            if (out_ready) mhold = 1'b0;
        end else if (clear) begin
            total = 0;
            terms = 0;
        end else if (in_valid) begin
            last_acc = 1'b1;
            total += int'(in_product);
            terms++;
            if (in_last || terms == 16) begin
                hold_exp[0] = expFor(total, terms, 16, 1'b1);
                hold_exp[1] = expFor(total, terms, 10, 1'b1);
                hold_exp[2] = expFor(total, terms, 10, 1'b0);
                q0.push_back(hold_exp[0]);
                q1.push_back(hold_exp[1]);
                q2.push_back(hold_exp[2]);
                mhold = 1'b1;
                total = 0;
                terms = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit v, input int p, input bit l, input bit c,
                                 input bit r, input bit rs);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_product = 8'(p);
        in_last    = l;
        clear      = c;
        out_ready  = r;
        reset      = rs;
        @(negedge clk);
        checkOutput();
        modelStep();
    endtask

    task automatic resetCheck(string tag);
        chk({tag, "_sum0"}, int'(sum0), 0);
        chk({tag, "_sum1"}, int'(sum1), 0);
        chk({tag, "_count0"}, int'(cnt0), 0);
        chk({tag, "_ovf2"}, int'(of2), 0);
    endtask

    initial begin
        bit hv;
        int hp;
        bit hl;
        errors     = 0;
        checks     = 0;
        mhold      = 1'b0;
        total      = 0;
        terms      = 0;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_product = 8'd0;
        in_last    = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b0;

        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        resetCheck("reset");

        // Short burst ending on in_last
        applyStimulus(1, 6, 0, 0, 1, 0);
        applyStimulus(1, 9, 0, 0, 1, 0);
        applyStimulus(1, 225, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Auto-termination at MAX_TERMS, then a 17th beat waits out the HOLD
        for (int i = 0; i < 16; i++) applyStimulus(1, 225, 0, 0, 0, 0);
        applyStimulus(1, 225, 1, 0, 0, 0);
        applyStimulus(1, 225, 1, 0, 0, 0);
        applyStimulus(1, 225, 1, 0, 1, 0);
        applyStimulus(1, 225, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Overflow in the 10-bit instances
        for (int i = 0; i < 4; i++) applyStimulus(1, 255, 0, 0, 1, 0);
        applyStimulus(1, 255, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Clear drops the burst and the beat presented with it
        applyStimulus(1, 100, 0, 0, 1, 0);
        applyStimulus(1, 50, 0, 0, 1, 0);
        applyStimulus(1, 7, 1, 1, 1, 0);
        applyStimulus(1, 3, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Back-pressured result, clear ignored during HOLD
        applyStimulus(1, 77, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1, 11, 0, (i == 2), 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Reset mid-burst
        applyStimulus(1, 40, 0, 0, 1, 0);
        applyStimulus(1, 40, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        resetCheck("midreset");
        applyStimulus(1, 8, 1, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Reset mid-HOLD discards the pending result
        applyStimulus(1, 90, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);

        // Random traffic; an unaccepted beat is held stable by the upstream
        hv = 1'b0;
        hp = 0;
        hl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!(hv && !last_acc)) begin
                hv = ($urandom_range(0, 99) < 70);
                hp = (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255)));
                hl = ($urandom_range(0, 99) < 15);
            end
            applyStimulus(hv, hp, hl,
                          ($urandom_range(0, 99) < 4),
                          ($urandom_range(0, 99) < 60),
                          ($urandom_range(0, 199) == 0));
        end

        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dadda_product_accumulator.md
Name: dadda_product_accumulator

Overview:
- Downstream consumer of the 4x4 unsigned Dadda multiplier's 8-bit product.
- Accepts one product per cycle over a valid/ready handshake and sums a burst of products into a wide accumulator, forming a multiply-accumulate (dot-product) datapath.
- A burst ends on an explicit last flag or after MAX_TERMS products. The total is then presented on a registered output handshake until it is consumed.

Parameters:
- PROD_W, 8, product width; must match the multiplier output (2x operand width).
- ACC_W, 16, accumulator/result width; must be >= PROD_W.
- MAX_TERMS, 16, maximum products per burst (>= 1); the count register is $clog2(MAX_TERMS+1) bits wide (CNT_W).
- SATURATE, 1, 1 = clamp the sum at all-ones on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  product valid
- in_ready  output  1  block can accept a product this cycle
- in_product  input  PROD_W  unsigned product from the multiplier
- in_last  input  1  qualifies in_product as the final term of the burst
- clear  input  1  synchronous abort of the current burst
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_sum  output  ACC_W  accumulated sum
- out_count  output  CNT_W  number of products in this sum
- out_overflow  output  1  a carry out of ACC_W occurred during the burst

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - State goes to ACCUM.
  - acc, count and the sticky overflow flag clear to 0.
  - out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - in_ready reads 1 in the cycle after reset deasserts.
- FSM has two states, ACCUM and HOLD.
- ACCUM:
  - in_ready = !clear.
  - Accept occurs when in_valid && in_ready.
  - On accept: acc <= acc + zero-extended in_product, computed ACC_W+1 wide. On carry-out, sticky ovf <= 1; acc <= all-ones if SATURATE, else the low ACC_W bits. Once ovf is set with SATURATE=1, acc stays all-ones. count <= count + 1.
  - Burst terminates when the accepted beat has in_last=1 or count+1 == MAX_TERMS.
  - On termination: out_sum, out_count and out_overflow load the post-add values; acc, count and ovf clear; out_valid <= 1; next state is HOLD.
  - Latency: result is visible the cycle after the last accept.
- HOLD:
  - in_ready=0; out_valid=1.
  - Outputs are stable until out_ready=1. On that edge out_valid <= 0 and the state returns to ACCUM, so the next accept is possible one cycle later (no accept in the handoff cycle).
  - Output data keeps its last value after out_valid falls.
- clear:
  - In ACCUM: acc, count and ovf zero next cycle; no output is produced; any in_valid that cycle is not accepted (in_ready=0).
  - In HOLD: ignored; the pending result is still delivered.
  - clear with in_last in the same cycle: clear wins, the beat is dropped.
- in_valid without in_ready: the upstream must hold in_product and in_last. The block never samples them.
- Zero products are legal; they still increment count.
- Reset mid-burst or mid-HOLD: all state is lost, out_valid drops in the next cycle, and nothing is emitted.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Maximum non-overflowing burst at defaults: 257 x 255 fits 16 bits, so MAX_TERMS=16 never overflows at defaults. Overflow tests use ACC_W=10.

Test Plan:
- Products 6, 9, 225 (in_last on 225), out_ready=1 -> one cycle later out_valid=1, out_sum=240, out_count=3, out_overflow=0. out_valid low the following cycle.
- 16 beats of 225, no in_last -> auto-terminate after the 16th accept; out_sum=3600, out_count=16. in_ready=0 while HOLD; a 17th beat is held off until out_ready.
- ACC_W=10, SATURATE=1: beats 255, 255, 255, 255, 255 (last) -> out_sum=1023, out_overflow=1, out_count=5. With SATURATE=0: out_sum=251 (1275 mod 1024), out_overflow=1.
- Beats 100, 50, then clear with in_valid=1, in_product=7 -> 7 not accepted. Next burst 3 (last) gives out_sum=3, out_count=1.
- Result pending with out_ready=0 for 5 cycles -> out_sum/out_count stable and in_ready=0 throughout. clear asserted during HOLD has no effect. out_ready=1 releases it, then in_ready=1 on the next cycle.
- reset asserted mid-burst after beats 40, 40 -> out_valid=0 and state cleared. A burst of 8 (last) then gives out_sum=8, out_count=1.
